// File: rtl/program_loader_if.sv
`default_nettype none
// ---- program_loader_if : byte-stream input and instruction-memory write port -- rev 1.0 ----
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              im_wr_en;
  logic [ADDR_W-1:0] im_wr_addr;
  logic [DATA_W-1:0] im_wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_wr_en, im_wr_addr, im_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_wr_en, im_wr_addr, im_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ---- program_loader : streams a program into instruction memory, checks its XOR sum, releases the core -- rev 1.0 ----
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  program_loader_if.slave   bus,
  output logic              core_enable,
  output logic              core_hold,
  output logic              done,
  output logic              error
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] csum_d;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              core_enable_q;
  logic              core_hold_q;
  logic              done_q;
  logic              error_q;
  logic              xfer;

  assign xfer    = bus.in_valid & in_ready_q;
  assign count_d = count_q + 1'b1;
  assign csum_d  = csum_q ^ bus.in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      count_q       <= '0;
      csum_q        <= '0;
      in_ready_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      core_enable_q <= 1'b0;
      core_hold_q   <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            // A zero length stands for a full 2^ADDR_W-byte image.
            len_q         <= (load_len == '0) ? FULL_LEN : {1'b0, load_len};
            count_q       <= '0;
            csum_q        <= '0;
            in_ready_q    <= 1'b1;
            core_enable_q <= 1'b0;
            core_hold_q   <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            state_q       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= count_q[ADDR_W-1:0];
            wr_data_q <= bus.in_data;
            csum_q    <= csum_d;
            count_q   <= count_d;
            if (count_d == len_q) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == csum_q) begin
              core_enable_q <= 1'b1;
              core_hold_q   <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= S_RUN;
            end else begin
              error_q <= 1'b1;
              state_q <= S_ERROR;
            end
          end
        end
        default: begin
          in_ready_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.im_wr_en   = wr_en_q;
  assign bus.im_wr_addr = wr_addr_q;
  assign bus.im_wr_data = wr_data_q;
  assign core_enable    = core_enable_q;
  assign core_hold      = core_hold_q;
  assign done           = done_q;
  assign error          = error_q;
endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ---- tb_program_loader : directed scoreboard bench for program_loader -- rev 1.0 ----
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              start    = 1'b0;
  logic [ADDR_W-1:0] load_len = '0;
  logic              core_enable;
  logic              core_hold;
  logic              done;
  logic              error;

  int          total  = 0;
  int          bad    = 0;
  int          wr_cnt = 0;
  int          wr_base;
  logic [15:0] exp_q[$];

  program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_len   (load_len),
    .bus        (bus.slave),
    .core_enable(core_enable),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe seen on the memory port must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.im_wr_en === 1'b1) begin
      wr_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_write: observed=%0h_%0h expected=none", bus.im_wr_addr, bus.im_wr_data);
      end
      if (exp_q.size() != 0) begin
        check("write", {16'h0, bus.im_wr_addr, bus.im_wr_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_start(input logic [7:0] len);
    start    = 1'b1;
    load_len = len;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit is_prog, input logic [7:0] addr);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.in_ready === 1'b1) begin
      if (is_prog) exp_q.push_back({addr, b});
      @(posedge clk); #1;
    end else begin
      check("handshake_timeout", {31'h0, bus.in_ready}, 32'h1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic en, input logic hold,
                              input logic dn, input logic er, input logic rdy);
    check(tag, {27'h0, core_enable, core_hold, done, error, bus.in_ready},
               {27'h0, en, hold, dn, er, rdy});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #2 reset = 1'b0;
    #1;
    check_status("reset_status", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_wr", {15'h0, bus.im_wr_en, bus.im_wr_addr, bus.im_wr_data}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_status("idle_no_ready", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic load: 0x41^0x52^0x13 == 0x00
    wr_base = wr_cnt;
    do_start(8'd3);
    check_status("load_entry", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h41, 1'b1, 8'h00);
    send(8'h52, 1'b1, 8'h01);
    send(8'h13, 1'b1, 8'h02);
    send(8'h00, 1'b0, 8'h00);
    check_status("basic_run", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("basic_wr_count", wr_cnt - wr_base, 3);

    // Restart from RUN, then a bad checksum
    do_start(8'd3);
    check_status("restart_from_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    wr_base = wr_cnt;
    send(8'h41, 1'b1, 8'h00);
    send(8'h52, 1'b1, 8'h01);
    send(8'h13, 1'b1, 8'h02);
    send(8'hFF, 1'b0, 8'h00);
    check_status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("bad_wr_count", wr_cnt - wr_base, 3);

    // Restart from ERROR; gaps and an ignored mid-load start
    do_start(8'd2);
    check_status("restart_from_error", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    wr_base = wr_cnt;
    send(8'hAA, 1'b1, 8'h00);
    start    = 1'b1;
    load_len = 8'd5;
    @(posedge clk); #1;
    start    = 1'b0;
    @(posedge clk); #1;
    check("gap_wr_count", wr_cnt - wr_base, 1);
    send(8'h55, 1'b1, 8'h01);
    send(8'hFF, 1'b0, 8'h00);
    check_status("gap_run", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("gap_wr_total", wr_cnt - wr_base, 2);

    // Full 256-byte image; XOR of 0..255 is 0
    do_start(8'd0);
    wr_base = wr_cnt;
    for (int i = 0; i < 256; i++) send(8'(i), 1'b1, 8'(i));
    check("full_last_wr", {15'h0, bus.im_wr_en, bus.im_wr_addr, bus.im_wr_data}, 32'h1_FFFF);
    check_status("full_in_check", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b0, 8'h00);
    check_status("full_run", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_wr_count", wr_cnt - wr_base, 256);

    // Reset in the middle of a load
    do_start(8'd3);
    send(8'h77, 1'b1, 8'h00);
    check("pre_reset_wr_en", {31'h0, bus.im_wr_en}, 32'h1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("reset_mid_wr", {15'h0, bus.im_wr_en, bus.im_wr_addr, bus.im_wr_data}, 32'h0);
    check_status("reset_mid_status", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    wr_base = wr_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    repeat (4) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_status("post_reset_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_no_wr", wr_cnt - wr_base, 0);

    @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart to the core's instruction fetch path.
- Accepts a program byte stream over a valid/ready handshake and writes it into the instruction memory's write port at incrementing addresses.
- Verifies an XOR checksum byte that trails the program.
- Holds the datapath stalled until a load completes cleanly, then asserts core_enable to the datapath's enable input.

Parameters:
- ADDR_W, 8, instruction memory address width; matches the PC width.
- DATA_W, 8, instruction/byte width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, RUN and ERROR.
- load_len  input  ADDR_W  program length in bytes, sampled on the accepted start; 0 means 2^ADDR_W (256).
- in_valid  input  1  source has a byte on in_data.
- in_data  input  DATA_W  program or checksum byte.
- in_ready  output  1  loader accepts a byte this cycle.
- im_wr_en  output  1  instruction memory write strobe.
- im_wr_addr  output  ADDR_W  instruction memory write address.
- im_wr_data  output  DATA_W  instruction memory write data.
- core_enable  output  1  drives the datapath enable; 1 only in RUN.
- core_hold  output  1  holds the datapath reset (PC to 0); 1 in every state except RUN.
- done  output  1  1 in RUN.
- error  output  1  1 in ERROR.

Behaviour:
- Reset values, forced asynchronously while reset=0:
  - state=IDLE; count=0; csum=0.
  - in_ready=0, im_wr_en=0, im_wr_addr=0, im_wr_data=0.
  - core_enable=0, core_hold=1, done=0, error=0.
- Handshake: a byte transfers on a rising edge where in_valid=1 and in_ready=1. in_ready is a registered function of state only; it never depends on in_valid.
- State IDLE:
  - in_ready=0.
  - On start: latch len (0 becomes 256) into a 9-bit register, clear count and csum, go to LOAD.
- State LOAD:
  - in_ready=1.
  - Each accepted byte registers im_wr_en=1, im_wr_addr=count[ADDR_W-1:0] and im_wr_data=in_data on the same edge. The write is visible one cycle after the handshake cycle and lasts one cycle.
  - Each accepted byte also updates csum ^= in_data and count += 1.
  - im_wr_en=0 on any edge without a transfer.
  - When the accepted byte makes count==len, go to CHECK.
  - start is ignored.
- State CHECK:
  - in_ready=1; no memory write.
  - The next accepted byte is compared with csum: equal goes to RUN, unequal goes to ERROR.
  - start is ignored.
- State RUN:
  - in_ready=0, core_hold=0, core_enable=1, done=1.
  - core_hold deasserts on the same edge that enters RUN, so the PC starts at 0.
  - On start: core_enable=0 and core_hold=1 on the next edge; go to LOAD exactly as from IDLE.
- State ERROR:
  - in_ready=0, error=1, core held.
  - On start: clear error and go to LOAD as from IDLE.
- Address wrap:
  - im_wr_addr uses count modulo 2^ADDR_W.
  - len=256 writes addresses 0x00..0xFF with no wrap.
  - count is 9 bits so that count==256 can be compared.
- Simultaneous events: in LOAD or CHECK, start together with a handshake means the handshake is processed and start is ignored.
- Reset mid-operation:
  - im_wr_en drops immediately (asynchronously).
  - The partial load is abandoned and memory contents beyond it are undefined.
  - After reset, core_hold=1 until a successful load completes.
- Throughput: one byte per cycle sustained; in_valid gaps stall without side effects.
- Latency: from the handshake of the checksum byte to done=1 is 1 edge.

Test Plan:
- Basic load:
  - Stimulus: start with load_len=3, then bytes 0x41,0x52,0x13 back-to-back, then checksum 0x00.
  - Required: writes (0x00,0x41), (0x01,0x52), (0x02,0x13), one per cycle; done=1, core_enable=1, core_hold=0 one edge after the checksum handshake.
- Bad checksum:
  - Stimulus: same program with checksum 0xFF.
  - Required: error=1, core_enable=0, core_hold=1; exactly 3 writes occurred. A following start returns to LOAD with error=0.
- Backpressure and gaps:
  - Stimulus: load_len=2 with in_valid toggling 1,0,0,1.
  - Required: im_wr_en pulses only after accepted bytes; addresses 0x00 then 0x01; no write during gaps.
- Full length:
  - Stimulus: load_len=0, then 256 bytes equal to the address value, then checksum 0x00.
  - Required: last write is (0xFF,0xFF); no write to 0x00 after it; done=1.
- Ignored and repeated start:
  - Stimulus: start asserted mid-LOAD.
  - Required: no effect on count or writes.
  - Stimulus: start asserted in RUN.
  - Required: core_enable=0 on the next edge, in_ready=1, and the new load begins at address 0x00.
- Reset mid-load:
  - Stimulus: reset=0 after 1 of 3 bytes.
  - Required: im_wr_en=0 immediately; all outputs at reset values; in_ready=0 until the next start.
